// File: rtl/pulse_gen_if.sv
// Trigger/control inputs and shaped outputs of the pulse generator.
interface pulse_gen_if #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 8
);
  logic [WIDTH-1:0] trig;
  logic [1:0]       mode;
  logic [CNT_W-1:0] len;
  logic             clr;
  logic [WIDTH-1:0] Y;
  logic [WIDTH-1:0] busy;
  logic [WIDTH-1:0] done;

  modport master (output trig, mode, len, clr, input Y, busy, done);
  modport slave  (input trig, mode, len, clr, output Y, busy, done);
endinterface

// File: rtl/pulse_gen.sv
// Multi-channel pulse generator: per channel, turns trigger pulses into a
// programmable-width one-shot (non-retriggerable or retriggerable) or a
// toggle level. Mode, length and clear are shared by all channels.
module pulse_gen #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 8
) (
  input logic         clk,
  input logic         rstn,
  pulse_gen_if.slave  bus
);

  typedef enum logic {
    IDLE = 1'b0,
    HIGH = 1'b1
  } state_t;

  state_t           state_q [WIDTH];
  state_t           state_d [WIDTH];
  logic [CNT_W-1:0] cnt_q   [WIDTH];
  logic [CNT_W-1:0] cnt_d   [WIDTH];
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] busy_q, busy_d;
  logic [WIDTH-1:0] done_q, done_d;
  logic [1:0]       mode_q;

  logic             mode_chg;
  logic             toggle_mode;
  logic             retrig_mode;
  logic [CNT_W-1:0] len_eff;

  assign mode_chg    = (bus.mode != mode_q);
  assign toggle_mode = (mode_q == 2'b00);
  assign retrig_mode = (mode_q == 2'b10);
  // A length of 0 is stretched to a single cycle.
  assign len_eff     = (bus.len == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : bus.len;

  // Per-channel next state: clr, then mode change, then trig, then count.
  always_comb begin
    for (int unsigned i = 0; i < WIDTH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      y_d[i]     = y_q[i];
      busy_d[i]  = busy_q[i];
      done_d[i]  = 1'b0;

      if (bus.clr || mode_chg) begin
        state_d[i] = IDLE;
        cnt_d[i]   = '0;
        y_d[i]     = 1'b0;
        busy_d[i]  = 1'b0;
      end else if (toggle_mode) begin
        state_d[i] = IDLE;
        busy_d[i]  = 1'b0;
        if (bus.trig[i]) begin
          y_d[i] = ~y_q[i];
        end
      end else begin
        unique case (state_q[i])
          IDLE: begin
            if (bus.trig[i]) begin
              state_d[i] = HIGH;
              cnt_d[i]   = len_eff;
              y_d[i]     = 1'b1;
              busy_d[i]  = 1'b1;
            end
          end
          HIGH: begin
            if (retrig_mode && bus.trig[i]) begin
              cnt_d[i] = len_eff;
            end else if (cnt_q[i] <= {{(CNT_W-1){1'b0}}, 1'b1}) begin
              state_d[i] = IDLE;
              cnt_d[i]   = '0;
              y_d[i]     = 1'b0;
              busy_d[i]  = 1'b0;
              done_d[i]  = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] - 1'b1;
            end
          end
          default: begin
            state_d[i] = IDLE;
          end
        endcase
      end
    end
  end

  // State, counters, outputs and the shared mode register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
      y_q    <= '0;
      busy_q <= '0;
      done_q <= '0;
      mode_q <= 2'b01;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      mode_q  <= bus.mode;
    end
  end

  assign bus.Y    = y_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule
